// File: rtl/z80_bus_pkg.sv
// +--------------------------------------------------------------------------+
// | z80_bus_pkg : shared Z80 I/O bus types, state encoding and defaults       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package z80_bus_pkg;

  localparam int DEV_IDX_W = 2;
  localparam int DEV_COUNT = 4;
  localparam logic [2:0] CFG_PREFIX_DEFAULT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_INTA    = 2'd2,
    ST_RECOVER = 2'd3
  } bus_state_t;

  // Active-low select bundle; all ones means nothing selected.
  typedef struct packed {
    logic                 iorq_n;
    logic                 cfg_cs_n;
    logic [DEV_COUNT-1:0] dev_cs_n;
  } sel_t;

  localparam sel_t SEL_NONE = '1;

endpackage

`default_nettype wire

// File: rtl/z80_io_decoder.sv
// +--------------------------------------------------------------------------+
// | z80_io_decoder : qualifies Z80 I/O cycles, latches address, drives selects|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module z80_io_decoder
  import z80_bus_pkg::*;
#(
  parameter int         WIN_BIT    = 7,
  parameter logic [2:0] CFG_PREFIX = CFG_PREFIX_DEFAULT,
  parameter int         TCNT_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_m1_n,
  input  logic                 i_iorq_n,
  input  logic                 i_rd_n,
  input  logic                 i_wr_n,
  input  logic [7:0]           i_addr,
  output logic                 o_iorq_n,
  output logic [DEV_IDX_W-1:0] o_device,
  output logic                 o_cfg_cs_n,
  output logic [DEV_COUNT-1:0] o_dev_cs_n,
  output logic                 o_wr,
  output logic                 o_cycle_start,
  output logic                 o_cycle_end,
  output logic                 o_inta,
  output logic [TCNT_W-1:0]    o_tcount
);

  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

  bus_state_t           state, next_state;
  sel_t                 sel, next_sel;
  logic [DEV_IDX_W-1:0] device, next_device;
  logic                 wr, next_wr;
  logic                 start, next_start;
  logic                 cend, next_cend;
  logic                 inta, next_inta;
  logic [TCNT_W-1:0]    tcount, next_tcount;
  logic [TCNT_W-1:0]    tcount_inc;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^i_addr[4:0];

  function automatic sel_t decode(input logic win, input logic [2:0] top);
    sel_t s;
    s = SEL_NONE;
    if (!win) begin
      s.iorq_n                = 1'b0;
      s.dev_cs_n[top[1:0]]    = 1'b0;
    end else if (top == CFG_PREFIX) begin
      s.cfg_cs_n = 1'b0;
    end
    return s;
  endfunction

  assign tcount_inc = (tcount == '1) ? tcount : tcount + TCNT_ONE;

  always_comb begin
    next_state  = state;
    next_sel    = SEL_NONE;
    next_device = device;
    next_wr     = wr;
    next_start  = 1'b0;
    next_cend   = 1'b0;
    next_inta   = 1'b0;
    next_tcount = tcount;
    case (state)
      ST_IDLE: begin
        if (!i_iorq_n && !i_m1_n) begin
          next_state  = ST_INTA;
          next_inta   = 1'b1;
          next_tcount = TCNT_ONE;
        end else if (!i_iorq_n && (!i_rd_n || !i_wr_n)) begin
          next_state  = ST_ACTIVE;
          next_sel    = decode(i_addr[WIN_BIT], i_addr[7:5]);
          next_device = i_addr[6:5];
          next_wr     = ~i_wr_n;
          next_start  = 1'b1;
          next_tcount = TCNT_ONE;
        end
      end
      ST_ACTIVE: begin
        if (i_iorq_n) begin
          next_state = ST_RECOVER;
          next_cend  = 1'b1;
        end else begin
          // Selects come from the address latched at cycle entry only.
          next_sel    = sel;
          next_tcount = tcount_inc;
        end
      end
      ST_INTA: begin
        if (i_iorq_n) begin
          next_state = ST_RECOVER;
          next_cend  = 1'b1;
        end else begin
          next_inta   = 1'b1;
          next_tcount = tcount_inc;
        end
      end
      ST_RECOVER: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      sel    <= SEL_NONE;
      device <= '0;
      wr     <= 1'b0;
      start  <= 1'b0;
      cend   <= 1'b0;
      inta   <= 1'b0;
      tcount <= '0;
    end else begin
      state  <= next_state;
      sel    <= next_sel;
      device <= next_device;
      wr     <= next_wr;
      start  <= next_start;
      cend   <= next_cend;
      inta   <= next_inta;
      tcount <= next_tcount;
    end
  end

  assign o_iorq_n      = sel.iorq_n;
  assign o_cfg_cs_n    = sel.cfg_cs_n;
  assign o_dev_cs_n    = sel.dev_cs_n;
  assign o_device      = device;
  assign o_wr          = wr;
  assign o_cycle_start = start;
  assign o_cycle_end   = cend;
  assign o_inta        = inta;
  assign o_tcount      = tcount;

endmodule

`default_nettype wire

// File: tb/tb_z80_io_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_z80_io_decoder : randomized transaction-level bench for z80_io_decoder |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_z80_io_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_n, iorq_n, rd_n, wr_n;
  logic [7:0] addr;
  wire        q_iorq_n, q_cfg_cs_n, q_wr, q_start, q_end, q_inta;
  wire [1:0]  q_device;
  wire [3:0]  q_dev_cs_n, q_tcount;

  int n_vec = 0;
  int n_err = 0;

  // Expected state that persists between bus cycles.
  logic [1:0] m_device;
  logic       m_wr;
  logic [3:0] m_tcount;

  typedef struct packed {
    logic       iorq_n;
    logic [1:0] device;
    logic       cfg_cs_n;
    logic [3:0] dev_cs_n;
    logic       wr;
    logic       start;
    logic       cend;
    logic       inta;
    logic [3:0] tcount;
  } obs_t;

  localparam obs_t RESET_OBS = {1'b1, 2'b00, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

  z80_io_decoder dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_m1_n       (m1_n),
    .i_iorq_n     (iorq_n),
    .i_rd_n       (rd_n),
    .i_wr_n       (wr_n),
    .i_addr       (addr),
    .o_iorq_n     (q_iorq_n),
    .o_device     (q_device),
    .o_cfg_cs_n   (q_cfg_cs_n),
    .o_dev_cs_n   (q_dev_cs_n),
    .o_wr         (q_wr),
    .o_cycle_start(q_start),
    .o_cycle_end  (q_end),
    .o_inta       (q_inta),
    .o_tcount     (q_tcount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d miscompares so far", n_err);
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    return {q_iorq_n, q_device, q_cfg_cs_n, q_dev_cs_n, q_wr, q_start, q_end, q_inta, q_tcount};
  endfunction

  function automatic obs_t idle_exp(input logic with_end);
    return {1'b1, m_device, 1'b1, 4'hF, m_wr, 1'b0, with_end, 1'b0, m_tcount};
  endfunction

  task automatic release_bus();
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic idle_clk(input string name);
    obs_t got, exp;
    @(negedge clk);
    got = sample();
    exp = idle_exp(1'b0);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s idle: got %h expected %h", name, got, exp);
    end
  endtask

  // One complete I/O or INTA cycle: IORQ_n held low for len clocks, then released.
  // lead=1 means the bus was driven during RECOVER, so one idle clock precedes entry.
  task automatic bus_cycle(input string name, input logic [7:0] a, input logic is_wr,
                           input logic is_inta, input int len, input logic chg,
                           input logic [7:0] alt, input int lead);
    obs_t got, exp;
    iorq_n = 1'b0;
    m1_n   = ~is_inta;
    rd_n   = is_inta ? 1'b1 : is_wr;
    wr_n   = is_inta ? 1'b1 : ~is_wr;
    addr   = a;
    for (int j = 0; j < lead; j++) begin
      @(negedge clk);
      got = sample();
      exp = idle_exp(1'b0);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s lead: got %h expected %h", name, got, exp);
      end
    end
    if (!is_inta) begin
      m_device = a[6:5];
      m_wr     = is_wr;
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      got = sample();
      exp          = idle_exp(1'b0);
      exp.start    = !is_inta && (k == 1);
      exp.inta     = is_inta;
      exp.tcount   = (k > 15) ? 4'd15 : 4'(k);
      if (!is_inta) begin
        if (a < 8'h80) begin
          exp.iorq_n   = 1'b0;
          exp.dev_cs_n = ~(4'b0001 << a[6:5]);
        end else if (a >= 8'hC0 && a < 8'hE0) begin
          exp.cfg_cs_n = 1'b0;
        end
      end
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s clk%0d: got %h expected %h", name, k, got, exp);
      end
      if (chg && k == 1) addr = alt;
    end
    release_bus();
    addr     = 8'($urandom);
    m_tcount = (len > 15) ? 4'd15 : 4'(len);
    @(negedge clk);
    got = sample();
    exp = idle_exp(1'b1);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s recover: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    release_bus();
    addr = 8'h00;
    m_device = 2'b00; m_wr = 1'b0; m_tcount = 4'h0;
    repeat (2) @(negedge clk);
    got = sample();
    n_vec++;
    if (got !== RESET_OBS) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", got, RESET_OBS);
    end
    reset = 1'b0;
    idle_clk("after_reset");
  endtask

  task automatic test_write_dev();
    bus_cycle("write_dev0", 8'h00, 1'b1, 1'b0, 3, 1'b0, 8'h00, 0);
    idle_clk("write_dev0");
  endtask

  task automatic test_read_cfg();
    bus_cycle("read_cfg", 8'hC0, 1'b0, 1'b0, 3, 1'b0, 8'h00, 0);
    idle_clk("read_cfg");
  endtask

  task automatic test_addr_hold();
    bus_cycle("addr_hold", 8'h40, 1'b1, 1'b0, 4, 1'b1, 8'h20, 0);
    idle_clk("addr_hold");
  endtask

  task automatic test_inta();
    bus_cycle("inta", 8'h00, 1'b0, 1'b1, 3, 1'b0, 8'h00, 0);
    idle_clk("inta");
  endtask

  task automatic test_no_select();
    bus_cycle("sys_a0", 8'hA0, 1'b1, 1'b0, 2, 1'b0, 8'h00, 0);
    idle_clk("sys_a0");
    bus_cycle("sys_e0", 8'hE0, 1'b0, 1'b0, 2, 1'b0, 8'h00, 0);
    idle_clk("sys_e0");
    // IORQ_n low without RD_n/WR_n must not start a cycle.
    iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 8'h60;
    idle_clk("iorq_only");
    idle_clk("iorq_only");
    bus_cycle("iorq_then_rd", 8'h60, 1'b0, 1'b0, 2, 1'b0, 8'h00, 0);
    idle_clk("iorq_then_rd");
  endtask

  task automatic test_reset_mid();
    obs_t got;
    iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b0; addr = 8'h00;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 got = sample();
    n_vec++;
    if (got !== RESET_OBS) begin
      n_err++;
      $display("FAIL reset_mid: got %h expected %h", got, RESET_OBS);
    end
    m_device = 2'b00; m_wr = 1'b0; m_tcount = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    bus_cycle("post_reset", 8'h00, 1'b1, 1'b0, 3, 1'b0, 8'h00, 0);
    idle_clk("post_reset");
  endtask

  task automatic test_back_to_back();
    bus_cycle("saturate", 8'h20, 1'b1, 1'b0, 20, 1'b0, 8'h00, 0);
    bus_cycle("b2b", 8'h60, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1);
    idle_clk("b2b");
  endtask

  task automatic test_random();
    int lead = 0;
    for (int i = 0; i < 40; i++) begin
      bus_cycle("random", 8'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                $urandom_range(1, 18), 1'($urandom), 8'($urandom), lead);
      if ($urandom_range(0, 2) == 0) begin
        lead = 1;
      end else begin
        lead = 0;
        repeat ($urandom_range(1, 3)) idle_clk("random_gap");
      end
    end
    if (lead == 1) idle_clk("random_tail");
  endtask

  initial begin
    test_reset();
    test_write_dev();
    test_read_cfg();
    test_addr_hold();
    test_inta();
    test_no_select();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
